// File: rtl/prog_ctr_fetch.sv
// Program counter and fetch sequencer for the 8-bit accumulator CPU (IDLE -> RUN -> DONE).
// Optional CYCLE_COUNT_EN adds a saturating 16-bit CycleCount output counting RUN cycles.
module prog_ctr_fetch #(
  parameter int PC_W       = 10,
  parameter int START_ADDR = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Start,
  input  logic            Halt,
  input  logic            BranchEn,
  input  logic            BranchCond,
  input  logic [PC_W-1:0] Target,
  output logic [PC_W-1:0] ProgCtr,
  output logic            FetchValid,
  output logic            Done,
  output logic            Overflow,
`ifdef CYCLE_COUNT_EN
  output logic [15:0]     CycleCount,
`endif
  output logic [1:0]      state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [PC_W-1:0] PC_START = PC_W'(START_ADDR);
  localparam logic [PC_W-1:0] PC_LAST  = '1;

  state_t state;

  // FetchValid has no ready partner: the consumer must take ProgCtr every cycle it is high.
  assign FetchValid = (state == RUN);
  assign Done       = (state == DONE);
  assign state_dbg  = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ProgCtr  <= '0;
      Overflow <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (Start) begin
            state    <= RUN;
            ProgCtr  <= PC_START;
            Overflow <= 1'b0;
          end
        end
        RUN: begin
          if (Halt) begin
            state <= DONE;
          end else if (BranchEn && BranchCond) begin
            ProgCtr <= Target;
          end else if (ProgCtr == PC_LAST) begin
            // Falling off the end of memory stops the run rather than wrapping.
            state    <= DONE;
            Overflow <= 1'b1;
          end else begin
            ProgCtr <= ProgCtr + PC_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CYCLE_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      CycleCount <= '0;
    end else if (state != RUN) begin
      if (Start) CycleCount <= '0;
    end else if (CycleCount != 16'hFFFF) begin
      CycleCount <= CycleCount + 16'd1;
    end
  end
`endif

endmodule
